// File: rtl/bsg_link_upstream_arbiter_pkg.sv
// Shared definitions for the upstream link arbiter: state encoding, id width
// helper and the default-configuration flit header layout.
package bsg_link_upstream_arbiter_pkg;

  // Channel tag width; a single-client build still carries a 1-bit tag.
  function automatic int unsigned link_id_width(input int unsigned num_chan);
    return (num_chan > 1) ? $clog2(num_chan) : 1;
  endfunction

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t StIdle   = 1'b0;
  localparam arb_state_t StLocked = 1'b1;

  localparam int unsigned LinkNumChan = 4;
  localparam int unsigned LinkWidth   = 64;
  localparam int unsigned LinkIdWidth = link_id_width(LinkNumChan);

  // Flit header for the default configuration: channel id in the MSBs.
  typedef struct packed {
    logic [LinkIdWidth-1:0]           id;
    logic [LinkWidth-LinkIdWidth-1:0] payload;
  } link_flit_t;

endpackage

// File: rtl/bsg_link_upstream_arbiter_if.sv
// Client-side request bundle and link-side output of the upstream arbiter.
interface bsg_link_upstream_arbiter_if
  import bsg_link_upstream_arbiter_pkg::*;
#(
  parameter int unsigned num_chan_p      = 4,
  parameter int unsigned width_p         = 64,
  parameter int unsigned id_width_p      = link_id_width(num_chan_p),
  parameter int unsigned payload_width_p = width_p - id_width_p
);

  logic [num_chan_p*payload_width_p-1:0] req_data_i;
  logic [num_chan_p-1:0]                 req_valid_i;
  logic [num_chan_p-1:0]                 req_last_i;
  logic [num_chan_p-1:0]                 req_ready_o;
  logic [width_p-1:0]                    link_data_o;
  logic                                  link_valid_o;
  logic                                  link_ready_i;
  logic [id_width_p-1:0]                 grant_id_o;
  logic                                  locked_o;

  // Arbiter view.
  modport slave (
    input  req_data_i, req_valid_i, req_last_i, link_ready_i,
    output req_ready_o, link_data_o, link_valid_o, grant_id_o, locked_o
  );

  // Clients plus link view.
  modport master (
    output req_data_i, req_valid_i, req_last_i, link_ready_i,
    input  req_ready_o, link_data_o, link_valid_o, grant_id_o, locked_o
  );

endinterface

// File: rtl/bsg_link_rr_pick.sv
// Rotating-priority encoder: scans upward from the channel after last_ptr and
// returns the first valid channel as one-hot plus encoded id.
module bsg_link_rr_pick
  import bsg_link_upstream_arbiter_pkg::*;
#(
  parameter int unsigned num_chan_p = 4,
  parameter int unsigned id_width_p = link_id_width(num_chan_p)
) (
  input  logic [num_chan_p-1:0] valid,
  input  logic [id_width_p-1:0] last_ptr,
  output logic [num_chan_p-1:0] grant_oh,
  output logic [id_width_p-1:0] grant_id,
  output logic                  any_v
);

  // First valid channel in rotated order; last_ptr itself is scanned last.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant_oh = '0;
    grant_id = '0;
    any_v    = 1'b0;
    for (int unsigned i = 1; i <= num_chan_p; i++) begin
      idx = (32'(last_ptr) + i) % num_chan_p;
      if (!any_v && valid[idx]) begin
        any_v         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = id_width_p'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_link_upstream_arbiter.sv
// Packet-granular round-robin arbiter sharing one upstream link core port
// among several clients. Each flit is tagged with its source channel id and
// held in a single registered output slot.
module bsg_link_upstream_arbiter
  import bsg_link_upstream_arbiter_pkg::*;
#(
  parameter int unsigned num_chan_p      = 4,
  parameter int unsigned width_p         = 64,
  parameter int unsigned id_width_p      = link_id_width(num_chan_p),
  parameter int unsigned payload_width_p = width_p - id_width_p
) (
  input logic                         core_clk_i,
  input logic                         core_reset_i,
  bsg_link_upstream_arbiter_if.slave  link_if
);

  typedef struct packed {
    logic [id_width_p-1:0]      id;
    logic [payload_width_p-1:0] payload;
  } flit_t;

  arb_state_t            state_q;
  logic [id_width_p-1:0] ptr_q;
  logic [id_width_p-1:0] lock_q;
  logic [id_width_p-1:0] grant_q;
  logic                  slot_v_q;
  flit_t                 slot_q;

  logic [num_chan_p-1:0]      pick_oh;
  logic [id_width_p-1:0]      pick_id;
  logic                       pick_any;
  logic [id_width_p-1:0]      sel_id;
  logic                       sel_v;
  logic [num_chan_p-1:0]      ready_mask;
  logic                       load_en;
  logic                       accept;
  logic                       sel_last;
  logic [payload_width_p-1:0] sel_payload;

  bsg_link_rr_pick #(
    .num_chan_p (num_chan_p),
    .id_width_p (id_width_p)
  ) rr_pick (
    .valid    (link_if.req_valid_i),
    .last_ptr (ptr_q),
    .grant_oh (pick_oh),
    .grant_id (pick_id),
    .any_v    (pick_any)
  );

  // Slot can take a new flit when empty or draining this cycle.
  assign load_en = ~slot_v_q | link_if.link_ready_i;

  // Select the serviced channel: fresh arbitration when idle, the lock owner otherwise.
  always_comb begin
    sel_id             = lock_q;
    sel_v              = link_if.req_valid_i[lock_q];
    ready_mask         = '0;
    ready_mask[lock_q] = 1'b1;
    if (state_q == StIdle) begin
      sel_id     = pick_id;
      sel_v      = pick_any;
      ready_mask = pick_oh;
    end
  end

  assign accept      = sel_v & load_en;
  assign sel_last    = link_if.req_last_i[sel_id];
  assign sel_payload = link_if.req_data_i[sel_id*payload_width_p +: payload_width_p];

  // Ready stays low while reset is held even though the empty slot would accept.
  assign link_if.req_ready_o = (load_en && !core_reset_i) ? ready_mask : '0;

  // Output slot: overwritten on a simultaneous drain and load.
  always_ff @(posedge core_clk_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      slot_v_q <= 1'b0;
      slot_q   <= '0;
    end else if (load_en) begin
      slot_v_q <= accept;
      if (accept) begin
        slot_q <= '{id: sel_id, payload: sel_payload};
      end
    end
  end

  // Packet-lock FSM and round-robin pointer update.
  always_ff @(posedge core_clk_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_q <= StIdle;
      ptr_q   <= id_width_p'(num_chan_p - 1);
      lock_q  <= '0;
      grant_q <= '0;
    end else if (accept) begin
      grant_q <= sel_id;
      if (state_q == StIdle) begin
        if (sel_last) begin
          ptr_q <= sel_id;
        end else begin
          state_q <= StLocked;
          lock_q  <= sel_id;
        end
      end else if (sel_last) begin
        state_q <= StIdle;
        ptr_q   <= lock_q;
      end
    end
  end

  assign link_if.link_data_o  = slot_q;
  assign link_if.link_valid_o = slot_v_q;
  assign link_if.grant_id_o   = grant_q;
  assign link_if.locked_o     = (state_q == StLocked);

endmodule

// File: tb/tb_bsg_link_upstream_arbiter.sv
// Scoreboard bench for the upstream link arbiter: client queues feed the DUT,
// hand-ordered expected flits are checked by a monitor as they leave the link.
module tb_bsg_link_upstream_arbiter;
  import bsg_link_upstream_arbiter_pkg::*;

  localparam int unsigned NumChan = 4;
  localparam int unsigned IdW     = 2;
  localparam int unsigned PayW    = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_link_upstream_arbiter_if #(.num_chan_p(NumChan), .width_p(64)) bus ();

  bsg_link_upstream_arbiter #(
    .num_chan_p (NumChan),
    .width_p    (64)
  ) dut (
    .core_clk_i   (clk),
    .core_reset_i (rst),
    .link_if      (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [PayW-1:0] q_pay  [NumChan][$];
  logic            q_last [NumChan][$];
  link_flit_t      exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input int ch, input logic [PayW-1:0] pay, input logic last);
    q_pay[ch].push_back(pay);
    q_last[ch].push_back(last);
  endtask

  task automatic expect_flit(input int ch, input logic [PayW-1:0] pay);
    link_flit_t f;
    f.id      = IdW'(ch);
    f.payload = pay;
    exp_q.push_back(f);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NumChan; i++) if (q_pay[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] flit(input int ch, input logic [PayW-1:0] pay);
    link_flit_t f;
    f.id      = IdW'(ch);
    f.payload = pay;
    return f;
  endfunction

  // Present queue heads to the DUT.
  task automatic drive_reqs();
    for (int i = 0; i < NumChan; i++) begin
      if (q_pay[i].size() > 0) begin
        bus.req_valid_i[i]                 = 1'b1;
        bus.req_data_i[i*PayW +: PayW]     = q_pay[i][0];
        bus.req_last_i[i]                  = q_last[i][0];
      end else begin
        bus.req_valid_i[i]                 = 1'b0;
        bus.req_data_i[i*PayW +: PayW]     = '0;
        bus.req_last_i[i]                  = 1'b0;
      end
    end
  endtask

  // Client driver: pop flits the DUT accepted at the last edge.
  initial begin
    logic [NumChan-1:0] fire;
    forever begin
      @(negedge clk);
      fire = bus.req_valid_i & bus.req_ready_o;
      @(posedge clk);
      if (rst) fire = '0;
      #1;
      for (int i = 0; i < NumChan; i++) begin
        if (fire[i] && q_pay[i].size() > 0) begin
          void'(q_pay[i].pop_front());
          void'(q_last[i].pop_front());
        end
      end
      drive_reqs();
    end
  end

  // Monitor: every flit leaving the link is matched against the scoreboard.
  initial begin
    link_flit_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.link_valid_o && bus.link_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_flit: got %h, required none", bus.link_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("link_flit", bus.link_data_o, e);
        end
      end
    end
  end

  task automatic wait_idle(input string name, output int locked_cycles);
    bit done;
    locked_cycles = 0;
    done          = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.locked_o) locked_cycles++;
      if (queues_empty() && exp_q.size() == 0 && !bus.link_valid_o) done = 1'b1;
    end
    chk({name, "_drained"}, 64'(done), 64'd1);
  endtask

  task automatic wait_sig(input string name, input bit want_locked);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = want_locked ? bus.locked_o : bus.link_valid_o;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got 0, required 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk;
    int run;
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.req_last_i   = '0;
    bus.link_ready_i = 1'b1;

    // Reset state, with requests already pending.
    #2;
    send(0, 62'h100, 1'b1);
    send(2, 62'h200, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_link_valid", 64'(bus.link_valid_o), 64'd0);
    chk("rst_link_data", bus.link_data_o, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_locked", 64'(bus.locked_o), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id_o), 64'd0);

    // ch0 and ch2 together: ch0 first after reset.
    step();
    expect_flit(0, 62'h100);
    expect_flit(2, 62'h200);
    rst = 1'b0;
    @(negedge clk);
    chk("first_valid_low", 64'(bus.link_valid_o), 64'd0);
    wait_idle("t1", lk);
    chk("t1_grant_id", 64'(bus.grant_id_o), 64'd2);

    // ptr=2: scan wraps 3,0,1.
    step();
    send(0, 62'h210, 1'b1);
    send(1, 62'h211, 1'b1);
    send(3, 62'h213, 1'b1);
    expect_flit(3, 62'h213);
    expect_flit(0, 62'h210);
    expect_flit(1, 62'h211);
    wait_idle("t1b", lk);

    // Lone requester granted regardless of pointer.
    step();
    send(0, 62'h400, 1'b1);
    expect_flit(0, 62'h400);
    wait_idle("single", lk);
    chk("single_grant_id", 64'(bus.grant_id_o), 64'd0);

    // ch1 3-flit packet vs. continuously valid ch3.
    step();
    send(1, 62'h111, 1'b0);
    send(1, 62'h112, 1'b0);
    send(1, 62'h113, 1'b1);
    send(3, 62'h301, 1'b1);
    send(3, 62'h302, 1'b1);
    expect_flit(1, 62'h111);
    expect_flit(1, 62'h112);
    expect_flit(1, 62'h113);
    expect_flit(3, 62'h301);
    expect_flit(3, 62'h302);
    wait_idle("t2", lk);
    chk("t2_locked_cycles", 64'(lk), 64'd2);
    chk("t2_grant_id", 64'(bus.grant_id_o), 64'd3);

    // All four channels busy: 0,1,2,3,0,1,2,3 with no bubble.
    step();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NumChan; c++) begin
        send(c, 62'(32'h1000 + r * 16 + c), 1'b1);
        expect_flit(c, 62'(32'h1000 + r * 16 + c));
      end
    end
    wait_sig("t3_valid", 1'b0);
    run = 0;
    for (int n = 0; n < 20; n++) begin
      if (!bus.link_valid_o) break;
      run++;
      @(negedge clk);
    end
    chk("t3_no_bubble", 64'(run), 64'd8);
    wait_idle("t3", lk);

    // Backpressure holding ch2 0xABC.
    step();
    bus.link_ready_i = 1'b0;
    send(2, 62'hABC, 1'b1);
    expect_flit(2, 62'hABC);
    expect_flit(0, 62'h0AA);
    wait_sig("t4_valid", 1'b0);
    step();
    send(0, 62'h0AA, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_data", bus.link_data_o, flit(2, 62'hABC));
      chk("bp_valid", 64'(bus.link_valid_o), 64'd1);
      chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    step();
    bus.link_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_reload_ready", 64'(bus.req_ready_o), 64'h1);
    @(negedge clk);
    chk("bp_no_bubble", 64'(bus.link_valid_o), 64'd1);
    wait_idle("t4", lk);

    // Set ptr=3, then ch0 locks and stalls while ch1 waits.
    step();
    send(3, 62'h333, 1'b1);
    expect_flit(3, 62'h333);
    wait_idle("t5_pre", lk);
    step();
    send(0, 62'h501, 1'b0);
    send(1, 62'h601, 1'b1);
    expect_flit(0, 62'h501);
    expect_flit(0, 62'h502);
    expect_flit(1, 62'h601);
    wait_sig("t5_lock", 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_locked", 64'(bus.locked_o), 64'd1);
      chk("stall_req_ready", 64'(bus.req_ready_o), 64'h1);
    end
    step();
    send(0, 62'h502, 1'b1);
    wait_idle("t5", lk);
    chk("t5_grant_id", 64'(bus.grant_id_o), 64'd1);

    // Asynchronous reset mid-packet.
    step();
    send(0, 62'h701, 1'b0);
    send(0, 62'h702, 1'b0);
    send(0, 62'h703, 1'b1);
    expect_flit(0, 62'h701);
    wait_sig("t6_lock", 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_link_valid", 64'(bus.link_valid_o), 64'd0);
    chk("arst_locked", 64'(bus.locked_o), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("arst_grant_id", 64'(bus.grant_id_o), 64'd0);
    for (int i = 0; i < NumChan; i++) begin
      q_pay[i].delete();
      q_last[i].delete();
    end
    repeat (2) step();
    send(3, 62'h803, 1'b1);
    send(0, 62'h800, 1'b1);
    expect_flit(0, 62'h800);
    expect_flit(3, 62'h803);
    step();
    rst = 1'b0;
    wait_idle("t6", lk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_link_upstream_arbiter.md
Name: bsg_link_upstream_arbiter

Overview:
- Shares one upstream DDR link core-side port among num_chan_p core clients.
- Round-robin arbitration at packet granularity: a multi-flit packet from one client is never interleaved with another client's flits.
- Each flit is tagged with its source channel id in the MSBs, so the far side can demux it.
- Sits in the core clock domain between core clients and the link's core_data_i/core_valid_i/core_ready_o; output is registered.

Parameters:
- num_chan_p, 4, number of requesting clients (>=2).
- width_p, 64, link flit width; must equal the upstream link core data width.
- id_width_p, $clog2(num_chan_p), channel tag width.
- payload_width_p, width_p-id_width_p, client payload bits per flit.

Ports:
- core_clk_i  in  1  core clock.
- core_reset_i  in  1  asynchronous, active-high reset.
- req_data_i  in  num_chan_p*payload_width_p  client payloads; channel i occupies slice i.
- req_valid_i  in  num_chan_p  per-client flit valid.
- req_last_i  in  num_chan_p  per-client end-of-packet marker, qualified by valid.
- req_ready_o  out  num_chan_p  per-client accept; a flit transfers when valid & ready.
- link_data_o  out  width_p  {channel id, payload} to the link core_data_i.
- link_valid_o  out  1  to the link core_valid_i.
- link_ready_i  in  1  from the link core_ready_o.
- grant_id_o  out  id_width_p  currently locked or last-granted channel.
- locked_o  out  1  high while a multi-flit packet is in progress.

Behaviour:
- Reset (async assert, sync-released use): link_valid_o=0, link_data_o=0, req_ready_o=0, state=IDLE, locked_o=0, rr pointer=num_chan_p-1 (channel 0 has highest priority first), grant_id_o=0.
- Output slot: one register holding a flit plus its valid bit.
  - load_en = !slot_v | link_ready_i.
  - Slot drains on link_valid_o & link_ready_i.
  - link_data_o/link_valid_o are held stable while valid & !ready.
- FSM IDLE:
  - Combinationally pick the first valid channel scanning from ptr+1 upward (mod num_chan_p).
  - req_ready_o[win]=load_en; all other bits 0.
  - On accept with last=1: stay IDLE, ptr<=win.
  - On accept with last=0: go to LOCKED, lock<=win.
- FSM LOCKED:
  - req_ready_o[lock]=load_en only; other clients are stalled regardless of valid.
  - If req_valid_i[lock] drops, wait; no timeout and no re-arbitration.
  - On accept with last=1: go to IDLE, ptr<=lock.
- Latency: an accepted flit appears on link_data_o the next cycle.
- Throughput: 1 flit/cycle sustained, including back-to-back packets from different channels (no bubble on IDLE re-arbitration).
- Tagging: link_data_o = {id_width_p'(chan), payload}; the id always equals the accepting channel.
- Simultaneous drain and load in one cycle: the slot is overwritten with the new flit and stays valid.
- Single valid requester: always granted, regardless of ptr.
- Wrap-around: ptr=num_chan_p-1 scans from channel 0.
- req_ready_o is never asserted for a channel without load_en; it may be asserted when that channel's valid=0 only if the same channel is locked.
- Reset mid-packet: the in-flight packet is truncated, the slot is cleared, and the link sees no further flits. Link-level recovery is the link reset's job.
- grant_id_o updates on every accept; locked_o = (state==LOCKED).

Decomposition:
- Shared link package holds:
  - the flit header struct {id, payload};
  - the arbiter state enum {IDLE, LOCKED};
  - a width helper for id_width_p (minimum 1).
- One natural sub-module: bsg_link_rr_pick. It is a combinational rotating-priority encoder: valid vector + last pointer -> one-hot winner + encoded id + any_v.

Test Plan:
- Reset release, ch0 and ch2 each send a 1-flit packet together, ready=1:
  - cycle 1: link_data_o id=0; cycle 2: id=2.
  - ptr ends at 2.
  - link_valid_o=0 before the first accept.
- ch1 sends a 3-flit packet (last on flit 3) while ch3 is continuously valid:
  - output ids 1,1,1 then 3;
  - locked_o high for exactly the 2 cycles after flits 1 and 2 are accepted.
- All 4 channels continuously valid with 1-flit packets, ready=1 for 8 cycles:
  - output ids 0,1,2,3,0,1,2,3, no bubbles.
- Backpressure: link_ready_i=0 for 5 cycles while the slot holds ch2 payload 0xABC:
  - link_data_o is stable at {2,0xABC} and req_ready_o=0;
  - on ready=1 the flit drains and the next flit loads the same cycle.
- ch0 locked after flit 1, then req_valid_i[0] drops for 3 cycles while ch1 is valid:
  - no ch1 flits are emitted;
  - ch0 resumes, last accepted, then ch1 is granted.
- core_reset_i asserted mid-packet asynchronously:
  - link_valid_o and locked_o go 0 immediately;
  - after release, ch0 has first priority.
